// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM states, default widths.
// Consumed by alu_exec_unit, alu_serial_shifter and the ALU control decoder.
package alu_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: start loads work/cnt, then shifts while cnt != 0.
// last flags the final step; step_val is the work value after the current step.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               left,
    input  logic               arith,
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               last,
    output logic [XLEN-1:0]    step_val
);

    logic [XLEN-1:0]    work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;

    always_comb begin
        if (left_q) begin
            step_val = {work_q[XLEN-2:0], 1'b0};
        end else begin
            step_val = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
        end
    end

    assign last = (cnt_q == SHAMT_W'(1));

    always_comb begin
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (start) begin
            work_d  = data;
            cnt_d   = shamt;
            left_d  = left;
            arith_d = arith;
        end else if (cnt_q != '0) begin
            work_d = step_val;
            cnt_d  = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready in and out; shifts iterate 1 bit/cycle.
// Define FAST_SHIFT_EN to replace the serial shifter with a barrel shift.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    alu_state_e         state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    alu_res;
    logic               alu_ill;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
`ifdef FAST_SHIFT_EN
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
            // only reached here with shamt == 0; nonzero shifts go serial
            ALU_SLL:  alu_res = op_a;
            ALU_SRL:  alu_res = op_a;
            ALU_SRA:  alu_res = op_a;
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

`ifndef FAST_SHIFT_EN
    logic            is_shift;
    logic            sh_start;
    logic            sh_last;
    logic [XLEN-1:0] sh_step;

    assign is_shift = (alu_ctrl == ALU_SLL) | (alu_ctrl == ALU_SRL)
                    | (alu_ctrl == ALU_SRA);

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (sh_start),
        .left     (alu_ctrl == ALU_SLL),
        .arith    (alu_ctrl == ALU_SRA),
        .data     (op_a),
        .shamt    (shamt),
        .last     (sh_last),
        .step_val (sh_step)
    );
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef FAST_SHIFT_EN
        sh_start  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifndef FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        sh_start = 1'b1;
                        state_d  = SHIFT;
                    end else
`endif
                    begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_ill;
                        state_d   = DONE;
                    end
                end
            end
`ifndef FAST_SHIFT_EN
            SHIFT: begin
                if (sh_last) begin
                    result_d  = sh_step;
                    zero_d    = (sh_step == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
